// File: rtl/methane_mem_pkg.sv
// Shared types and helpers for the methane memory arbiter.
package methane_mem_pkg;

  typedef enum logic [1:0] {
    s_arb_idle  = 2'd0,
    s_arb_issue = 2'd1,
    s_arb_wait  = 2'd2,
    s_arb_resp  = 2'd3
  } s_mem_arb;

  typedef enum logic {
    req_if = 1'b0,
    req_d  = 1'b1
  } requester_id;

  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & MISALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise data has fixed priority.
module mem_arb_pick
  import methane_mem_pkg::*;
(
  input  logic        if_req,
  input  logic        d_req,
`ifdef MEM_ARB_RR_EN
  input  requester_id last_grant,
`endif
  output logic        grant_vld,
  output requester_id grant_id
);

  // Grant decision
  always_comb begin
    grant_vld = if_req | d_req;
    grant_id  = req_if;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      grant_id = (last_grant == req_d) ? req_if : req_d;
    end else if (d_req) begin
      grant_id = req_d;
    end else begin
      grant_id = req_if;
    end
`else
    if (d_req) begin
      grant_id = req_d;
    end else begin
      grant_id = req_if;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port BRAM between the fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed data priority.
module mem_arbiter
  import methane_mem_pkg::*;
#(
  parameter int MEM_AW       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              busy
);

  localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

  s_mem_arb          state_r, state_s;
  requester_id       gid_r, gid_s;
  logic [3:0]        we_r, we_s;
  logic [2:0]        cnt_r, cnt_s;

  logic              if_valid_r, if_valid_s;
  logic              if_err_r, if_err_s;
  logic [31:0]       if_rdata_r, if_rdata_s;
  logic              d_valid_r, d_valid_s;
  logic              d_err_r, d_err_s;
  logic [31:0]       d_rdata_r, d_rdata_s;
  logic              mem_en_r, mem_en_s;
  logic [3:0]        mem_we_r, mem_we_s;
  logic [MEM_AW-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]       mem_din_r, mem_din_s;
  logic              busy_r, busy_s;

  logic              grant_vld_s;
  requester_id       grant_id_s;
  logic [31:0]       sel_addr_s;
  logic [3:0]        sel_we_s;
  logic [31:0]       sel_wdata_s;
  logic              resp_s, resp_err_s, rdata_upd_s;
  logic [31:0]       rdata_new_s;
  logic              unused_addr_s;

  // Address bits above the BRAM range alias and are deliberately dropped.
  assign unused_addr_s = ^{if_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2]};

`ifdef MEM_ARB_RR_EN
  requester_id lg_r, lg_s;

  assign lg_s = (state_r == s_arb_idle && grant_vld_s) ? grant_id_s : lg_r;

  // Last-grant history for round-robin
  always_ff @(posedge clk) begin
    if (rst) begin
      lg_r <= req_if;
    end else begin
      lg_r <= lg_s;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (lg_r),
`endif
    .grant_vld  (grant_vld_s),
    .grant_id   (grant_id_s)
  );

  assign sel_addr_s  = (grant_id_s == req_d) ? d_addr  : if_addr;
  assign sel_we_s    = (grant_id_s == req_d) ? d_we    : 4'b0000;
  assign sel_wdata_s = (grant_id_s == req_d) ? d_wdata : 32'h0000_0000;

  // Next state, memory port and response event
  always_comb begin
    state_s     = state_r;
    gid_s       = gid_r;
    we_s        = we_r;
    cnt_s       = cnt_r;
    mem_en_s    = 1'b0;
    mem_we_s    = 4'b0000;
    mem_addr_s  = mem_addr_r;
    mem_din_s   = mem_din_r;
    resp_s      = 1'b0;
    resp_err_s  = 1'b0;
    rdata_upd_s = 1'b0;
    rdata_new_s = 32'h0000_0000;
    case (state_r)
      s_arb_idle: begin
        if (grant_vld_s) begin
          gid_s = grant_id_s;
          we_s  = sel_we_s;
          if (is_misaligned(sel_addr_s)) begin
            state_s     = s_arb_resp;
            resp_s      = 1'b1;
            resp_err_s  = 1'b1;
            rdata_upd_s = 1'b1;
          end else begin
            state_s    = s_arb_issue;
            mem_en_s   = 1'b1;
            mem_we_s   = sel_we_s;
            mem_addr_s = sel_addr_s[MEM_AW+1:2];
            mem_din_s  = sel_wdata_s;
          end
        end else begin
          state_s = s_arb_idle;
        end
      end
      s_arb_issue: begin
        if (we_r != 4'b0000) begin
          state_s = s_arb_resp;
          resp_s  = 1'b1;
        end else begin
          state_s = s_arb_wait;
          cnt_s   = CNT_LOAD;
        end
      end
      s_arb_wait: begin
        if (cnt_r == 3'd0) begin
          state_s     = s_arb_resp;
          resp_s      = 1'b1;
          rdata_upd_s = 1'b1;
          rdata_new_s = mem_dout;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      s_arb_resp: state_s = s_arb_idle;
      default:    state_s = s_arb_idle;
    endcase
  end

  assign busy_s = (state_s != s_arb_idle);

  // Route the response to the granted requester; the other side holds its rdata.
  always_comb begin
    if_valid_s = 1'b0;
    if_err_s   = 1'b0;
    if_rdata_s = if_rdata_r;
    d_valid_s  = 1'b0;
    d_err_s    = 1'b0;
    d_rdata_s  = d_rdata_r;
    if (resp_s && gid_s == req_d) begin
      d_valid_s = 1'b1;
      d_err_s   = resp_err_s;
      d_rdata_s = rdata_upd_s ? rdata_new_s : d_rdata_r;
    end else if (resp_s) begin
      if_valid_s = 1'b1;
      if_err_s   = resp_err_s;
      if_rdata_s = rdata_upd_s ? rdata_new_s : if_rdata_r;
    end else begin
      if_valid_s = 1'b0;
      d_valid_s  = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= s_arb_idle;
      gid_r      <= req_if;
      we_r       <= 4'b0000;
      cnt_r      <= 3'd0;
      if_valid_r <= 1'b0;
      if_err_r   <= 1'b0;
      if_rdata_r <= 32'h0000_0000;
      d_valid_r  <= 1'b0;
      d_err_r    <= 1'b0;
      d_rdata_r  <= 32'h0000_0000;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 4'b0000;
      mem_addr_r <= '0;
      mem_din_r  <= 32'h0000_0000;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      gid_r      <= gid_s;
      we_r       <= we_s;
      cnt_r      <= cnt_s;
      if_valid_r <= if_valid_s;
      if_err_r   <= if_err_s;
      if_rdata_r <= if_rdata_s;
      d_valid_r  <= d_valid_s;
      d_err_r    <= d_err_s;
      d_rdata_r  <= d_rdata_s;
      mem_en_r   <= mem_en_s;
      mem_we_r   <= mem_we_s;
      mem_addr_r <= mem_addr_s;
      mem_din_r  <= mem_din_s;
      busy_r     <= busy_s;
    end
  end

  assign if_valid = if_valid_r;
  assign if_err   = if_err_r;
  assign if_rdata = if_rdata_r;
  assign d_valid  = d_valid_r;
  assign d_err    = d_err_r;
  assign d_rdata  = d_rdata_r;
  assign mem_en   = mem_en_r;
  assign mem_we   = mem_we_r;
  assign mem_addr = mem_addr_r;
  assign mem_din  = mem_din_r;
  assign busy     = busy_r;

endmodule
